pio_wr_mirror_fifo: RTL

- Sits directly downstream of the PIO write-only BRAM block.
- Consumes that block's registered write-out stream (wr_active/wr_addr/wr_data) and buffers it in a small flop FIFO.
- Drains the buffer into a replica table over a valid/ready port, so a remote copy of a PIO-programmed table tracks the local one.
- Optionally merges back-to-back writes to the same address; counts and flags dropped writes for software.

---
 rtl/pio_wr_mirror_fifo_pkg.sv | 15 +
 rtl/pio_mirror_fifo_core.sv | 71 +++++++
 rtl/pio_wr_mirror_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/pio_wr_mirror_fifo_pkg.sv
// rtl/pio_wr_mirror_fifo_pkg.sv - shared defaults and entry layout for the PIO write mirror FIFO
package pio_wr_mirror_fifo_pkg;

  localparam int DEF_WIDTH       = 20;
  localparam int DEF_DEPTH_NBITS = 1;
  localparam int DEF_FIFO_NBITS  = 2;
  localparam int DEF_MERGE_EN    = 1;
  localparam int DEF_CNT_NBITS   = 16;

  // A FIFO entry is packed as {addr, data}; the address sits in the upper bits.
  function automatic int entry_width(input int addr_nbits, input int data_nbits);
    return addr_nbits + data_nbits;
  endfunction

endpackage

// File: rtl/pio_mirror_fifo_core.sv
// rtl/pio_mirror_fifo_core.sv - flop FIFO with push/pop and a tail-entry rewrite port
module pio_mirror_fifo_core
  import pio_wr_mirror_fifo_pkg::*;
#(
  parameter int DW = 21,
  parameter int AW = 2,
  parameter int KW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          tail_we,
  input  logic [DW-1:0] tail_data,
  output logic [DW-1:0] head_data,
  output logic [KW-1:0] tail_key,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;
  logic [DW-1:0] tail_entry;

  // Most recently pushed entry; only meaningful while count != 0.
  assign tail_ptr   = wr_ptr - AW'(1);
  assign tail_entry = mem[tail_ptr];
  assign tail_key   = tail_entry[DW-1 -: KW];
  assign head_data  = mem[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);

  // Storage array is not reset; a push and a tail rewrite never coincide.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end else if (tail_we) begin
      mem[tail_ptr] <= tail_data;
    end
  end

  // Pointer and occupancy tracking; both pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pio_wr_mirror_fifo.sv
// rtl/pio_wr_mirror_fifo.sv - buffers PIO table writes and drains them to a replica table
module pio_wr_mirror_fifo
  import pio_wr_mirror_fifo_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH_NBITS = DEF_DEPTH_NBITS,
  parameter int FIFO_NBITS  = DEF_FIFO_NBITS,
  parameter int MERGE_EN    = DEF_MERGE_EN,
  parameter int CNT_NBITS   = DEF_CNT_NBITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_active,
  input  logic [DEPTH_NBITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   mir_ready,
  input  logic                   ovf_clr,
  output logic                   mir_valid,
  output logic [DEPTH_NBITS-1:0] mir_addr,
  output logic [WIDTH-1:0]       mir_data,
  output logic                   mir_idle,
  output logic                   ovf_sticky,
  output logic [CNT_NBITS-1:0]   drop_cnt,
  output logic [FIFO_NBITS:0]    fifo_cnt
);

  localparam int                    EW        = entry_width(DEPTH_NBITS, WIDTH);
  localparam logic [CNT_NBITS-1:0]  DROP_SAT  = '1;
  localparam logic [CNT_NBITS-1:0]  DROP_ONE  = CNT_NBITS'(1);
  localparam logic [FIFO_NBITS:0]   OCC_ONE   = (FIFO_NBITS+1)'(1);

  logic [EW-1:0]          new_entry;
  logic [EW-1:0]          head_entry;
  logic [DEPTH_NBITS-1:0] tail_addr;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   merge_hit;
  logic                   push;
  logic                   drop;

  assign new_entry = {wr_addr, wr_data};
  assign {mir_addr, mir_data} = head_entry;

  assign mir_valid = ~fifo_empty;
  assign pop       = mir_valid & mir_ready;

  // A write to the tail's address folds into it, unless that tail is the last
  // entry and is leaving this cycle; the write then becomes a fresh push.
  assign merge_hit = (MERGE_EN != 0) & wr_active & ~fifo_empty &
                     (wr_addr == tail_addr) & ~(pop & (fifo_cnt == OCC_ONE));
  assign push      = wr_active & ~merge_hit & (~fifo_full | pop);
  assign drop      = wr_active & ~merge_hit & ~push;

  assign mir_idle  = fifo_empty & ~wr_active;

  pio_mirror_fifo_core #(
    .DW (EW),
    .AW (FIFO_NBITS),
    .KW (DEPTH_NBITS)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .tail_we   (merge_hit),
    .tail_data (new_entry),
    .head_data (head_entry),
    .tail_key  (tail_addr),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Drop accounting; a drop in the clearing cycle survives as the first new drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= drop;
      drop_cnt   <= drop ? DROP_ONE : '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (drop_cnt != DROP_SAT) begin
        drop_cnt <= drop_cnt + DROP_ONE;
      end
    end
  end

endmodule
